// File: rtl/cmd_decoder_pkg.sv
// Shared opcodes, FSM encoding and 16-bit WORD/RESP field layouts for the host command decoder.
package cmd_decoder_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_RESET   = 8'h01;
  localparam logic [3:0] OP_TRIG_HI = 4'h1;
  localparam logic [7:0] OP_WRITE   = 8'h20;
  localparam logic [7:0] OP_READ    = 8'h21;
  localparam logic [7:0] OP_WORD    = 8'h30;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PAIR_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_CMD,
    S_EVAL,
    S_WAIT_B0,
    S_FETCH_B0,
    S_WAIT_B1,
    S_FETCH_B1,
    S_EXEC,
    S_TRIG_WAIT,
    S_TRIG,
    S_WORD,
    S_RESP,
    S_SOFTRST
  } state_t;

  // Read-back layout: address in the high byte, zero-extended register data low.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } resp_t;

  // WORD payload layout: first payload byte is the high byte.
  typedef struct packed {
    logic [7:0] msb;
    logic [7:0] lsb;
  } word_t;

  // Opcodes carrying at least one payload byte.
  function automatic logic has_payload(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ) || (op == OP_WORD);
  endfunction

endpackage

// File: rtl/cmd_decoder_if.sv
// RX FIFO pop port plus the WORD and RESP valid/accept ports of the command decoder.
interface cmd_decoder_if;
  import cmd_decoder_pkg::*;

  logic [7:0] rx_rdata;
  logic       rx_rempty;
  logic       rx_hold;
  logic       rx_rinc;

  word_t      word_data;
  logic       word_valid;
  logic       word_accept;

  resp_t      resp_data;
  logic       resp_valid;
  logic       resp_accept;

  modport master (
    input  rx_rdata, rx_rempty, rx_hold, word_accept, resp_accept,
    output rx_rinc, word_data, word_valid, resp_data, resp_valid
  );

  modport slave (
    output rx_rdata, rx_rempty, rx_hold, word_accept, resp_accept,
    input  rx_rinc, word_data, word_valid, resp_data, resp_valid
  );

endinterface

// File: rtl/cmd_timeout.sv
// Loadable down-counter; expired_c flags an enabled cycle with the count already at zero.
module cmd_timeout #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic             expired_c
);

  logic [WIDTH-1:0] cnt_q;

  // Count register: clear beats load beats decrement, stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired_c = en && (cnt_q == '0);

endmodule

// File: rtl/cmd_decoder.sv
// Host command decoder: pops opcodes/payloads, owns the register file, fires triggers, forwards words and read-backs.
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned REG_W    = 8,
  parameter int unsigned NUM_TRIG = 4,
  parameter int unsigned TRIG_LEN = 2,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cmd_decoder_if.master             bus,
  output logic                      fifo_rst_n,
  output logic [NUM_REGS*REG_W-1:0] regs,
  output logic [NUM_TRIG-1:0]       trig,
  input  logic [NUM_TRIG-1:0]       trig_busy,
  output logic [7:0]                err_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DW_W  = $clog2(TRIG_LEN + 2);

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, b0_q, b1_q;
  logic [DW_W-1:0]     dwell_q;
  logic [NUM_TRIG-1:0] trig_hit;
  logic [REG_W-1:0]    rd_data_c;

  logic rx_ready_c, trig_ok_c, busy_c, addr_ok_c;
  logic err_inc_c, reg_we_c, reg_clr_c, resp_load_c, word_load_c;
  logic tmo_clr_c, tmo_load_c, tmo_en_c, tmo_expired_c;

  assign rx_ready_c = !bus.rx_rempty && !bus.rx_hold;
  assign trig_ok_c  = ({1'b0, cmd_q[3:0]} < 5'(NUM_TRIG));
  assign addr_ok_c  = ({1'b0, b0_q} < 9'(NUM_REGS));
  assign busy_c     = |(trig_busy & trig_hit);
  assign reg_clr_c  = (state_q == S_SOFTRST);

  assign tmo_clr_c  = (state_q == S_IDLE);
  assign tmo_load_c = (state_q == S_EVAL) || (state_q == S_FETCH_B0);
  assign tmo_en_c   = (state_q == S_WAIT_B0) || (state_q == S_WAIT_B1) ||
                      (state_q == S_TRIG_WAIT);

  // Shared timeout for payload waits and busy trigger targets.
  cmd_timeout #(.WIDTH(CNT_W)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmo_clr_c),
    .load      (tmo_load_c),
    .value     (CNT_W'(TIMEOUT - 1)),
    .en        (tmo_en_c),
    .expired_c (tmo_expired_c)
  );

  // State register plus cycles spent in the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= (state_d == state_q) ? dwell_q + DW_W'(1) : '0;
    end
  end

  // Next-state decode and single-cycle strobes.
  always_comb begin
    state_d     = state_q;
    err_inc_c   = 1'b0;
    reg_we_c    = 1'b0;
    resp_load_c = 1'b0;
    word_load_c = 1'b0;
    case (state_q)
      S_IDLE:      if (rx_ready_c) state_d = S_FETCH_CMD;
      S_FETCH_CMD: state_d = S_EVAL;
      S_EVAL: begin
        if (cmd_q == OP_NOP) begin
          state_d = S_IDLE;
        end else if (cmd_q == OP_RESET) begin
          state_d = S_SOFTRST;
        end else if (has_payload(cmd_q)) begin
          state_d = S_WAIT_B0;
        end else if ((cmd_q[7:4] == OP_TRIG_HI) && trig_ok_c) begin
          state_d = busy_c ? S_TRIG_WAIT : S_TRIG;
        end else begin
          err_inc_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_B0: begin
        if (rx_ready_c) begin
          state_d = S_FETCH_B0;
        end else if (tmo_expired_c) begin
          err_inc_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FETCH_B0:  state_d = (cmd_q == OP_READ) ? S_EXEC : S_WAIT_B1;
      S_WAIT_B1: begin
        if (rx_ready_c) begin
          state_d = S_FETCH_B1;
        end else if (tmo_expired_c) begin
          err_inc_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FETCH_B1:  state_d = S_EXEC;
      S_EXEC: begin
        if (cmd_q == OP_WRITE) begin
          reg_we_c  = addr_ok_c;
          err_inc_c = !addr_ok_c;
          state_d   = S_IDLE;
        end else if (cmd_q == OP_READ) begin
          resp_load_c = 1'b1;
          err_inc_c   = !addr_ok_c;
          state_d     = S_RESP;
        end else begin
          word_load_c = 1'b1;
          state_d     = S_WORD;
        end
      end
      S_TRIG_WAIT: begin
        if (!busy_c) begin
          state_d = S_TRIG;
        end else if (tmo_expired_c) begin
          err_inc_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_TRIG:      if (dwell_q == DW_W'(TRIG_LEN - 1)) state_d = S_IDLE;
      S_WORD:      if (bus.word_accept) state_d = S_IDLE;
      S_RESP:      if (bus.resp_accept) state_d = S_IDLE;
      S_SOFTRST:   if (dwell_q == DW_W'(1)) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Moore outputs registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rx_rinc    <= 1'b0;
      fifo_rst_n     <= 1'b0;
      bus.word_valid <= 1'b0;
      bus.resp_valid <= 1'b0;
      trig           <= '0;
    end else begin
      bus.rx_rinc    <= (state_d == S_FETCH_CMD) || (state_d == S_FETCH_B0) ||
                        (state_d == S_FETCH_B1);
      fifo_rst_n     <= (state_d != S_SOFTRST);
      bus.word_valid <= (state_d == S_WORD);
      bus.resp_valid <= (state_d == S_RESP);
      trig           <= (state_d == S_TRIG) ? trig_hit : '0;
    end
  end

  // Byte capture in the fetch cycles and WORD/RESP payload loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q         <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      bus.word_data <= '0;
      bus.resp_data <= '0;
    end else begin
      if (state_q == S_FETCH_CMD) cmd_q <= bus.rx_rdata;
      if (state_q == S_FETCH_B0)  b0_q  <= bus.rx_rdata;
      if (state_q == S_FETCH_B1)  b1_q  <= bus.rx_rdata;
      if (word_load_c) bus.word_data <= '{msb: b0_q, lsb: b1_q};
      if (resp_load_c) bus.resp_data <= '{addr: b0_q, data: 8'(rd_data_c)};
    end
  end

  // Saturating error counter, kept across soft reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_inc_c && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  // Register file: one entry per generate iteration, flattened onto regs.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [REG_W-1:0] q;

    // Entry k: cleared by hard or soft reset, loaded by an in-range WRITE.
    always_ff @(posedge clk) begin
      if (!rst_n || reg_clr_c) begin
        q <= '0;
      end else if (reg_we_c && (b0_q == 8'(k))) begin
        q <= b1_q[REG_W-1:0];
      end
    end

    assign regs[k*REG_W +: REG_W] = q;
  end

  // Read-back mux; out-of-range addresses return zero.
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (b0_q == 8'(k)) rd_data_c = regs[k*REG_W +: REG_W];
    end
  end

  // One-hot trigger select from the opcode low nibble.
  for (genvar k = 0; k < NUM_TRIG; k++) begin : g_trig
    assign trig_hit[k] = (cmd_q[3:0] == 4'(k));
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed self-checking bench for cmd_decoder with a byte-queue model of the RX FIFO.
module tb_cmd_decoder;
  import cmd_decoder_pkg::*;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned NUM_TRIG = 4;
  localparam int unsigned TRIG_LEN = 3;
  localparam int unsigned TIMEOUT  = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic fifo_rst_n;
  logic [NUM_REGS*REG_W-1:0] regs;
  logic [NUM_TRIG-1:0] trig;
  logic [NUM_TRIG-1:0] trig_busy;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  cmd_decoder_if bus ();

  cmd_decoder #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .NUM_TRIG(NUM_TRIG),
    .TRIG_LEN(TRIG_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_rst_n (fifo_rst_n),
    .regs       (regs),
    .trig       (trig),
    .trig_busy  (trig_busy),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  assign bus.rx_rdata  = fifo_mem[rd_ptr[9:0]];
  assign bus.rx_rempty = (rd_ptr == wr_ptr);

  // FIFO head advances on the edge that ends a pop cycle.
  always @(posedge clk) begin
    if (bus.rx_rinc && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (rd_ptr == wr_ptr) begin
        done = 1'b1;
        break;
      end
    end
    repeat (4) tick();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: %0d bytes left, required 0", wr_ptr - rd_ptr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({regs, trig, bus.rx_rinc, bus.word_valid, bus.resp_valid, err_count, fifo_rst_n} !==
        {32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: regs=%h trig=%h rinc=%b wv=%b rv=%b err=%h frst=%b required all 0",
               regs, trig, bus.rx_rinc, bus.word_valid, bus.resp_valid, err_count, fifo_rst_n);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (fifo_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: fifo_rst_n=%b required 1", fifo_rst_n);
    end
  endtask

  task automatic test_write_read();
    logic ok;
    push(8'h20); push(8'h01); push(8'hA5); push(8'h21); push(8'h01); push(8'h00);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL resp_wait: resp_valid=%b required 1", bus.resp_valid);
    end
    checks++;
    if (regs !== 32'h0000_A500) begin
      errors++;
      $display("FAIL write_reg: regs=%h required 0000a500", regs);
    end
    checks++;
    if (bus.resp_data !== 16'h01A5) begin
      errors++;
      $display("FAIL resp_data: got %h required 01a5", bus.resp_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.resp_valid, bus.rx_rinc} !== 2'b10) begin
        errors++;
        $display("FAIL resp_hold: valid=%b rinc=%b required 1 0", bus.resp_valid, bus.rx_rinc);
      end
    end
    bus.resp_accept = 1'b1;
    tick();
    bus.resp_accept = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_drop: valid=%b required 0", bus.resp_valid);
    end
    wait_drain(20);
  endtask

  task automatic test_trig_free();
    logic [3:0] exp;
    push(8'h11);
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = (c >= 3 && c <= 5) ? 4'h2 : 4'h0;
      checks++;
      if (trig !== exp) begin
        errors++;
        $display("FAIL trig_free c%0d: trig=%h required %h", c, trig, exp);
      end
      if (c == 1) begin
        checks++;
        if (bus.rx_rinc !== 1'b1) begin
          errors++;
          $display("FAIL rinc_cycle1: rinc=%b required 1", bus.rx_rinc);
        end
      end
    end
    wait_drain(10);
  endtask

  task automatic test_trig_busy();
    logic [3:0] exp;
    trig_busy = 4'b0100;
    push(8'h12);
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (trig !== 4'h0) begin
        errors++;
        $display("FAIL trig_busy_hold c%0d: trig=%h required 0", c, trig);
      end
    end
    trig_busy = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp = (c <= 3) ? 4'h4 : 4'h0;
      checks++;
      if (trig !== exp) begin
        errors++;
        $display("FAIL trig_busy_pulse c%0d: trig=%h required %h", c, trig, exp);
      end
    end
    wait_drain(10);
  endtask

  task automatic test_word();
    logic ok;
    push(8'h30); push(8'h12); push(8'h34); push(8'h00);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.word_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus.word_data !== 16'h1234) begin
      errors++;
      $display("FAIL word_data: valid=%b data=%h required 1 1234", bus.word_valid, bus.word_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.word_valid, bus.rx_rinc} !== 2'b10 || (wr_ptr - rd_ptr) != 1) begin
        errors++;
        $display("FAIL word_hold: valid=%b rinc=%b left=%0d required 1 0 1",
                 bus.word_valid, bus.rx_rinc, wr_ptr - rd_ptr);
      end
    end
    bus.word_accept = 1'b1;
    tick();
    bus.word_accept = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL word_drop: valid=%b required 0", bus.word_valid);
    end
    wait_drain(20);
  endtask

  task automatic test_timeout();
    push(8'h20); push(8'h07);
    repeat (50) tick();
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL timeout_early: err=%0d required 0", err_count);
    end
    repeat (80) tick();
    checks++;
    if (err_count !== 8'd1 || regs !== 32'h0000_A500) begin
      errors++;
      $display("FAIL timeout_abort: err=%0d regs=%h required 1 0000a500", err_count, regs);
    end
    push(8'h00);
    wait_drain(10);
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL nop_after_timeout: err=%0d required 1", err_count);
    end
  endtask

  task automatic test_errors();
    push(8'h5F); push(8'h14); push(8'h20); push(8'h09); push(8'hFF);
    wait_drain(40);
    checks++;
    if (err_count !== 8'd4 || regs !== 32'h0000_A500 || trig !== 4'h0) begin
      errors++;
      $display("FAIL bad_cmds: err=%0d regs=%h trig=%h required 4 0000a500 0", err_count, regs, trig);
    end
    for (int i = 0; i < 300; i++) push(8'h5F);
    wait_drain(1500);
    checks++;
    if (err_count !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate: err=%h required ff", err_count);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    push(8'h11);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (trig != 4'h0) begin
        ok = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (!ok || trig !== 4'h0 || fifo_rst_n !== 1'b0 || err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_trig: seen=%b trig=%h frst=%b err=%h required 1 0 0 00",
               ok, trig, fifo_rst_n, err_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (fifo_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: fifo_rst_n=%b required 1", fifo_rst_n);
    end
    push(8'h21); push(8'h01);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus.resp_data !== 16'h0100) begin
      errors++;
      $display("FAIL resp_after_reset: valid=%b data=%h required 1 0100", bus.resp_valid, bus.resp_data);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || fifo_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resp: valid=%b frst=%b required 0 0", bus.resp_valid, fifo_rst_n);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (fifo_rst_n !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resp_release: frst=%b valid=%b required 1 0", fifo_rst_n, bus.resp_valid);
    end
  endtask

  task automatic test_softrst();
    logic exp;
    push(8'h5F); push(8'h20); push(8'h02); push(8'h5A);
    wait_drain(30);
    checks++;
    if (regs !== 32'h005A_0000 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL pre_softrst: regs=%h err=%0d required 005a0000 1", regs, err_count);
    end
    push(8'h01);
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      checks++;
      if (fifo_rst_n !== exp) begin
        errors++;
        $display("FAIL softrst c%0d: fifo_rst_n=%b required %b", c, fifo_rst_n, exp);
      end
    end
    checks++;
    if (regs !== 32'h0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL softrst_regs: regs=%h err=%0d required 0 1", regs, err_count);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    trig_busy       = '0;
    bus.rx_hold     = 1'b0;
    bus.word_accept = 1'b0;
    bus.resp_accept = 1'b0;
    test_reset();
    test_write_read();
    test_trig_free();
    test_trig_busy();
    test_word();
    test_timeout();
    test_errors();
    test_reset_mid();
    test_softrst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Parametrised host-command decoder that sits between the RX FIFO (FT245 side) and the instrument sub-blocks. It pops command bytes and their payloads, and maintains a generic register file (peltier duty cycles, readout mode, …). It fires trigger pulses to sub-blocks (MCP3008, CCD readout, …), forwards 16-bit words to a word consumer (AD9826 config), and returns register read-backs on a valid/accept port feeding tx_mux. It replaces the fixed-size decoder in the top level with configurable register count, trigger count, pulse width and payload timeout.

## Interface
Parameters:
- NUM_REGS, 4 — register-file depth; 1..256
- REG_W, 8 — register width; 1..8
- NUM_TRIG, 4 — trigger outputs; 1..16
- TRIG_LEN, 2 — trigger pulse width in clk cycles; ≥1
- TIMEOUT, 65535 — max wait cycles for a payload byte or a free trigger target

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- rx_rdata  in  8  RX FIFO head byte, valid while rx_rempty=0
- rx_rempty  in  1  RX FIFO empty
- rx_hold  in  1  FT245 busy; no pop while high
- rx_rinc  out  1  pop strobe, one cycle per byte
- fifo_rst_n  out  1  RX/TX FIFO reset, active low
- regs  out  NUM_REGS*REG_W  flattened register file, reg k at [k*REG_W +: REG_W]
- trig  out  NUM_TRIG  trigger pulses
- trig_busy  in  NUM_TRIG  target busy; trigger k waits while bit k high
- word_data  out  16  {b0,b1} payload of WORD command
- word_valid  out  1  word offered
- word_accept  in  1  word taken
- resp_data  out  16  {addr, zero-extended reg data}
- resp_valid  out  1  response offered
- resp_accept  in  1  response taken
- err_count  out  8  saturating error counter

## Operation
- Opcodes: 0x00 NOP; 0x01 RESET; 0x10+k TRIG k; 0x20 WRITE addr,data; 0x21 READ addr; 0x30 WORD msb,lsb.
- States: IDLE, FETCH_CMD, EVAL, WAIT_B0, FETCH_B0, WAIT_B1, FETCH_B1, EXEC, TRIG_WAIT, TRIG, WORD, RESP, SOFTRST.
- IDLE → FETCH_CMD when rx_rempty=0 and rx_hold=0. FETCH_* assert rx_rinc and capture rx_rdata in the same cycle.
- WAIT_Bn → FETCH_Bn under the same condition. EVAL routes by opcode; payload-less opcodes skip WAIT_B0.
- Unknown opcode, or TRIG k with k≥NUM_TRIG: err_count+1 → IDLE.
- WRITE with addr<NUM_REGS: regs[addr]<=data[REG_W-1:0] in EXEC. With addr≥NUM_REGS: ignored, err+1.
- READ: resp_data={addr, addr<NUM_REGS ? reg : 0}. Addr out of range counts as err+1. Hold resp_valid in RESP until resp_accept.
- WORD: hold word_valid in WORD until word_accept.
- TRIG k: wait in TRIG_WAIT while trig_busy[k]=1, then drive trig[k]=1 for exactly TRIG_LEN cycles → IDLE. Only one trig bit is ever high.
- RESET: clear regs, drive fifo_rst_n=0 for 2 cycles (SOFTRST), then → IDLE. err_count is kept.
- Timeout: a counter runs in WAIT_B0, WAIT_B1 and TRIG_WAIT. At TIMEOUT cycles it aborts to IDLE with err+1. Consumed bytes are dropped.
- err_count saturates at 0xFF.

## Timing
- rst_n=0 sampled: next edge regs=0, trig=0, rx_rinc=0, word_valid=0, resp_valid=0, err_count=0, fifo_rst_n=0, state IDLE. fifo_rst_n goes to 1 on the first edge with rst_n=1.
- Reset mid-command or mid-pulse aborts on that edge; pending word and response are dropped.
- rx_rinc is a Moore output of the FETCH states. rx_rempty falling in IDLE (cycle 0) gives rx_rinc at cycle 1 and EVAL at cycle 2.
- TRIG with a free target: trig high in cycles 3..3+TRIG_LEN-1.
- WRITE: the last payload pop precedes EXEC by 1 cycle; the regs update is visible 1 cycle after EXEC.
- Valid/accept: transfer on a cycle with both high. Valid drops the next cycle, state → IDLE. No byte is popped while valid is high.

## Structure
- Package cmd_decoder_pkg: opcode localparams, state encoding, and the RESP/WORD 16-bit field layout; shared with tx_mux header constants.
- Sub-module cmd_timeout: loadable down-counter with clear/enable/expired, used for both the payload and TRIG_WAIT timeouts.
- Register file and trigger one-hot are generate-loops inside cmd_decoder.

## Test plan
- Stream 0x20,0x01,0xA5 then 0x21,0x01 → regs[1]=0xA5; resp_data=0x01A5, held while resp_accept=0 for 5 cycles, drops the cycle after accept.
- 0x12 with trig_busy[2]=1 for 10 cycles, TRIG_LEN=3 → trig=0x4 for exactly 3 cycles, starting 1 cycle after busy falls.
- 0x30,0x12,0x34 → word_data=0x1234, word_valid held until word_accept; rx_rinc stays 0 meanwhile.
- 0x20,0x07 (NUM_REGS=4), FIFO then empty for TIMEOUT=100 cycles → abort, err_count=1, regs unchanged. Next 0x00 decodes normally.
- 0x5F and 0x20,0x09,0xFF → err_count=2. Then 300 bad opcodes → err_count=0xFF.
- rst_n low during a trig pulse and during an RESP wait → trig=0, resp_valid=0, fifo_rst_n=0 next edge, 1 on the first edge after release. 0x01 → regs=0, fifo_rst_n low 2 cycles.
